cmp_stream_tracker: RTL and testbench

Downstream consumer of the 4-bit magnitude comparator. It accepts one comparison result (lt/gt/eq) per handshake, keeps saturating per-outcome counters, and runs an equality-streak state machine that raises a lock indication after LOCK_LEN consecutive equal results. It sits between the comparator and the status/readout logic.

---
 rtl/cmp_stream_tracker_pkg.sv | 30 +++
 rtl/cmp_stream_tracker_sat_counter.sv | 32 +++
 rtl/cmp_stream_tracker.sv | 130 +++++++++++++
 tb/tb_cmp_stream_tracker.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cmp_stream_tracker_pkg.sv
// cmp_stream_tracker_pkg: shared types and constants for the comparator stream tracker
//   state_t        : equality-streak FSM encoding (IDLE=0, RUN=1, LOCK=2)
//   outcome_t      : decoded comparator outcome (LT, GT, EQ, or BAD for a non-one-hot sample)
//   STREAK_W       : width of the streak counter
//   decode_outcome : priority decode eq > gt > lt, optionally flagging non-one-hot inputs
package cmp_stream_tracker_pkg;

    localparam int STREAK_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OUT_LT  = 2'd0,
        OUT_GT  = 2'd1,
        OUT_EQ  = 2'd2,
        OUT_BAD = 2'd3
    } outcome_t;

    // flags = {lt, gt, eq}; all-zero falls through to lt unless checking is on
    function automatic outcome_t decode_outcome(input logic [2:0] flags, input logic chk);
        return (chk && !(flags inside {3'b100, 3'b010, 3'b001})) ? OUT_BAD :
               flags[0] ? OUT_EQ :
               flags[1] ? OUT_GT : OUT_LT;
    endfunction

endpackage

// File: rtl/cmp_stream_tracker_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear to zero (wins over inc)
//   inc        : increment request; ignored once the count is all-ones
//   count      : current count (registered)
//   at_max     : count is all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_q, count_d;

    assign count  = count_q;
    assign at_max = &count_q;

    always_comb begin
        count_d = clr ? '0 : (inc && !at_max) ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/cmp_stream_tracker.sv
// cmp_stream_tracker: counts comparator outcomes and detects runs of equal results
//   clk, rst                : clock, synchronous active-high reset
//   in_valid / in_ready     : sample handshake; in_ready = !sat & !clr & !rst
//   lt, gt, eq              : comparator flags of the presented sample
//   clr                     : synchronous clear of counters, streak, FSM and sticky flags
//   lt_cnt, gt_cnt, eq_cnt  : saturating per-outcome counters (CNT_W bits)
//   streak                  : consecutive eq count, saturates at 255
//   locked, lock_pulse      : in LOCK state / one-cycle pulse on LOCK entry
//   sat                     : some counter is all-ones (holds until clr/rst)
//   flag_err                : sticky non-one-hot sample seen
// Optional feature: define CMP_TRACK_ONEHOT_CHECK_EN to reject non-one-hot samples.
module cmp_stream_tracker
    import cmp_stream_tracker_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                lt,
    input  logic                gt,
    input  logic                eq,
    input  logic                clr,
    output logic [CNT_W-1:0]    lt_cnt,
    output logic [CNT_W-1:0]    gt_cnt,
    output logic [CNT_W-1:0]    eq_cnt,
    output logic [STREAK_W-1:0] streak,
    output logic                locked,
    output logic                lock_pulse,
    output logic                sat,
    output logic                flag_err
);

    localparam logic [STREAK_W-1:0] LOCK_V = LOCK_LEN[STREAK_W-1:0];

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                lock_pulse_q, lock_pulse_d;
    logic                lt_max, gt_max, eq_max;
    logic                accept;
    outcome_t            outcome;

    // Counters only clear together with sat, so the OR of their at_max
    // flags is already sticky until clr or rst.
    assign sat        = lt_max | gt_max | eq_max;
    assign in_ready   = !sat && !clr && !rst;
    assign accept     = in_valid && in_ready;
    assign streak     = streak_q;
    assign locked     = state_q == ST_LOCK;
    assign lock_pulse = lock_pulse_q;

`ifdef CMP_TRACK_ONEHOT_CHECK_EN
    logic flag_err_q, flag_err_d;

    assign outcome  = decode_outcome({lt, gt, eq}, 1'b1);
    assign flag_err = flag_err_q;

    always_comb begin
        flag_err_d = clr ? 1'b0 : flag_err_q || (accept && outcome == OUT_BAD);
    end

    always_ff @(posedge clk) begin
        if (rst) flag_err_q <= 1'b0;
        else     flag_err_q <= flag_err_d;
    end
`else
    assign outcome  = decode_outcome({lt, gt, eq}, 1'b0);
    assign flag_err = 1'b0;
`endif

    // Any accepted non-eq sample (including a rejected BAD one) breaks the run.
    always_comb begin
        streak_d     = streak_q;
        state_d      = state_q;
        lock_pulse_d = 1'b0;
        if (clr) begin
            streak_d = '0;
            state_d  = ST_IDLE;
        end else if (accept && outcome == OUT_EQ) begin
            streak_d     = (&streak_q) ? streak_q : streak_q + 1'b1;
            lock_pulse_d = state_q == ST_RUN && streak_d == LOCK_V;
            state_d      = (lock_pulse_d || state_q == ST_LOCK) ? ST_LOCK : ST_RUN;
        end else if (accept) begin
            streak_d = '0;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            streak_q     <= '0;
            lock_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            lock_pulse_q <= lock_pulse_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .inc    (accept && outcome == OUT_LT),
        .count  (lt_cnt),
        .at_max (lt_max)
    );

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .inc    (accept && outcome == OUT_GT),
        .count  (gt_cnt),
        .at_max (gt_max)
    );

    sat_counter #(.W(CNT_W)) u_eq_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .inc    (accept && outcome == OUT_EQ),
        .count  (eq_cnt),
        .at_max (eq_max)
    );

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// tb_cmp_stream_tracker: directed self-checking bench for cmp_stream_tracker (CNT_W=4, LOCK_LEN=4)
module tb_cmp_stream_tracker;

    logic       clk = 1'b0;
    logic       rst, in_valid, lt, gt, eq, clr;
    logic       in_ready, locked, lock_pulse, sat, flag_err;
    logic [3:0] lt_cnt, gt_cnt, eq_cnt;
    logic [7:0] streak;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    cmp_stream_tracker #(.CNT_W(4), .LOCK_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lt         (lt),
        .gt         (gt),
        .eq         (eq),
        .clr        (clr),
        .lt_cnt     (lt_cnt),
        .gt_cnt     (gt_cnt),
        .eq_cnt     (eq_cnt),
        .streak     (streak),
        .locked     (locked),
        .lock_pulse (lock_pulse),
        .sat        (sat),
        .flag_err   (flag_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic g, input logic e, input logic c);
        in_valid = v; lt = l; gt = g; eq = e; clr = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int el, input int eg, input int ee,
                           input int es, input logic elk, input logic elp, input logic esat);
        chk({tag, ".lt_cnt"}, lt_cnt, el);
        chk({tag, ".gt_cnt"}, gt_cnt, eg);
        chk({tag, ".eq_cnt"}, eq_cnt, ee);
        chk({tag, ".streak"}, streak, es);
        chk({tag, ".locked"}, locked, elk);
        chk({tag, ".lock_pulse"}, lock_pulse, elp);
        chk({tag, ".sat"}, sat, esat);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst.in_ready", in_ready, 0);
        chk_all("rst", 0, 0, 0, 0, 0, 0, 0);
        chk("rst.flag_err", flag_err, 0);
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", in_ready, 1);

        // four back-to-back eq samples lock on the fourth
        drive(1, 0, 0, 1, 0);
        tick(); tick(); tick();
        chk_all("eq3", 0, 0, 3, 3, 0, 0, 0);
        tick();
        chk_all("eq4", 0, 0, 4, 4, 1, 1, 0);
        drive(0, 0, 0, 1, 0);
        tick();
        chk_all("eq4_hold", 0, 0, 4, 4, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        tick();
        chk_all("lock_gt", 0, 1, 4, 0, 0, 0, 0);

        // clear, then eq,eq,eq,gt,eq stays unlocked and leaves RUN with streak 1
        drive(0, 0, 0, 0, 1);
        tick();
        chk_all("clr1", 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        tick(); tick(); tick();
        chk_all("s_eq3", 0, 0, 3, 3, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        tick();
        chk_all("s_gt", 0, 1, 3, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        tick();
        chk_all("s_eq1", 0, 1, 4, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        tick();
        chk_all("s_idle_hold", 0, 1, 4, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        tick(); tick(); tick();
        chk_all("s_relock", 0, 1, 7, 4, 1, 1, 0);

        // clr with a simultaneous eq sample drops the sample
        drive(1, 0, 0, 1, 1);
        #1;
        chk("clr_eq.in_ready", in_ready, 0);
        tick();
        chk_all("clr_eq", 0, 0, 0, 0, 0, 0, 0);

        // non-one-hot {lt,gt,eq}=101 during a streak of 2, then all-zero flags
        drive(1, 0, 0, 1, 0);
        tick(); tick();
        chk_all("pre_bad", 0, 0, 2, 2, 0, 0, 0);
        drive(1, 1, 0, 1, 0);
        tick();
`ifdef CMP_TRACK_ONEHOT_CHECK_EN
        chk_all("bad101", 0, 0, 2, 0, 0, 0, 0);
        chk("bad101.flag_err", flag_err, 1);
`else
        chk_all("bad101", 0, 0, 3, 3, 0, 0, 0);
        chk("bad101.flag_err", flag_err, 0);
`endif
        drive(1, 0, 0, 0, 0);
        tick();
`ifdef CMP_TRACK_ONEHOT_CHECK_EN
        chk_all("zero_flags", 0, 0, 2, 0, 0, 0, 0);
        chk("zero_flags.flag_err", flag_err, 1);
`else
        chk_all("zero_flags", 1, 0, 3, 0, 0, 0, 0);
        chk("zero_flags.flag_err", flag_err, 0);
`endif
        drive(0, 0, 0, 0, 1);
        tick();
        chk_all("clr2", 0, 0, 0, 0, 0, 0, 0);
        chk("clr2.flag_err", flag_err, 0);

        // saturate lt_cnt at 15 and hold off further samples
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 14; i++) tick();
        chk_all("lt14", 14, 0, 0, 0, 0, 0, 0);
        chk("lt14.in_ready", in_ready, 1);
        tick();
        chk_all("lt15", 15, 0, 0, 0, 0, 0, 1);
        chk("lt15.in_ready", in_ready, 0);
        tick();
        chk_all("lt16", 15, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 1, 0);
        tick();
        chk_all("sat_eq", 15, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        chk_all("clr_sat", 0, 0, 0, 0, 0, 0, 0);
        chk("clr_sat.in_ready", in_ready, 1);

        // reset while locked with eq_cnt=9
        drive(1, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) tick();
        chk_all("eq9", 0, 0, 9, 9, 1, 0, 0);
        rst = 1'b1;
        tick();
        chk_all("rst_lock", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        chk_all("rst_lock_after", 0, 0, 0, 0, 0, 0, 0);
        chk("rst_lock_after.in_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
